// File: rtl/cla_serial_adder_ctrl.sv
// Multi-cycle WIDTH-bit adder: one shared 4-bit carry-lookahead slice is
// walked LSB-first over the operands, one nibble per clock. The inter-slice
// carry is kept in a register. The result is handed off over a valid/ready
// handshake.
// Optional build macro CLA_SERIAL_SUB_EN adds a 'sub' input. When sub=1 the
// block computes a-b, and c_out=1 means no borrow.
module cla_serial_adder_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
`ifdef CLA_SERIAL_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             busy
);
  localparam int N  = WIDTH / 4;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  generate
    if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
      $error("cla_serial_adder_ctrl: WIDTH must be a multiple of 4 and >= 4");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, nxt;

  logic [WIDTH-1:0] a_sh, b_sh, acc, acc_nxt, b_ld;
  logic [CW-1:0]    cnt;
  logic             carry, carry_ld, last, accept;
  logic [3:0]       p, g, c, snib;

  // Operand conditioning at accept: subtract is a + ~b + 1
`ifdef CLA_SERIAL_SUB_EN
  assign b_ld     = sub ? ~b : b;
  assign carry_ld = sub ? 1'b1 : c_in;
`else
  assign b_ld     = b;
  assign carry_ld = c_in;
`endif

  assign accept = in_valid && in_ready;
  assign last   = (cnt == CW'(N - 1));

  // One 4-bit lookahead slice on the low nibble of the operand shifters
  always_comb begin
    p    = a_sh[3:0] ^ b_sh[3:0];
    g    = a_sh[3:0] & b_sh[3:0];
    c[0] = g[0] | (p[0] & carry);
    c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry);
    c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & carry);
    c[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & carry);
    snib = p ^ {c[2:0], carry};
    // new nibble enters at the MSB end so that the LSB nibble ends at the bottom
    acc_nxt = (acc >> 4) | (WIDTH'(snib) << (WIDTH - 4));
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  // Next-state logic
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (accept) nxt = RUN;
      RUN:     if (last) nxt = DONE;
      DONE:    if (out_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Handshake and status outputs, decoded from the state
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state == RUN) || (state == DONE);
  end

  // Datapath: operand shifters, carry, working sum, and the published result.
  // The published sum is updated only on completion, so it holds the last
  // result until the next operation finishes.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh  <= '0;
      b_sh  <= '0;
      acc   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      c_out <= 1'b0;
    end else if (state == IDLE) begin
      if (accept) begin
        a_sh  <= a;
        b_sh  <= b_ld;
        carry <= carry_ld;
        cnt   <= '0;
      end
    end else if (state == RUN) begin
      a_sh  <= a_sh >> 4;
      b_sh  <= b_sh >> 4;
      acc   <= acc_nxt;
      carry <= c[3];
      cnt   <= cnt + CW'(1);
      if (last) begin
        sum   <= acc_nxt;
        c_out <= c[3];
      end
    end
  end
endmodule

// File: tb/tb_cla_serial_adder_ctrl.sv
// Self-checking bench for cla_serial_adder_ctrl (WIDTH=16). Expected results
// come from plain integer arithmetic on the operands.
module tb_cla_serial_adder_ctrl;
  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, c_in, out_valid, out_ready, c_out, busy;
  logic [15:0] a, b, sum;
  logic        sub;
  int          checks = 0;
  int          failures = 0;

  cla_serial_adder_ctrl #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c_in(c_in),
`ifdef CLA_SERIAL_SUB_EN
    .sub(sub),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .c_out(c_out), .busy(busy)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full operation: accept, measure latency, check result, hold for
  // 'hold' cycles of backpressure, then release. If 'pulse' is set, a stray
  // in_valid with a=0xAAAA is driven during RUN and must be ignored.
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic tc,
                        input logic tsub, input int hold, input bit pulse);
    logic [16:0] full;
    logic [15:0] exp_s;
    logic        exp_c;
    int          lat;
    if (tsub) begin
      exp_s = ta - tb_v;
      exp_c = (ta >= tb_v);
    end else begin
      full  = 17'(ta) + 17'(tb_v) + 17'(tc);
      exp_s = full[15:0];
      exp_c = full[16];
    end
    check("ready_before_accept", 32'(in_ready), 32'd1);
    a = ta; b = tb_v; c_in = tc; sub = tsub; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    a = $urandom; b = $urandom; c_in = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 20) begin
      if (!(in_ready == 1'b0 && busy == 1'b1)) check("run_ready_busy", {30'd0, in_ready, busy}, 32'b01);
      if (pulse && lat == 2) begin
        a = 16'hAAAA; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      step();
      lat++;
    end
    in_valid = 1'b0;
    check("latency", 32'(lat), 32'd4);
    check("sum", 32'(sum), 32'(exp_s));
    check("c_out", 32'(c_out), 32'(exp_c));
    for (int i = 0; i < hold; i++) begin
      step();
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_sum", {15'd0, c_out, sum}, {15'd0, exp_c, exp_s});
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("release_valid", 32'(out_valid), 32'd0);
    check("release_ready", 32'(in_ready), 32'd1);
    check("retain_sum", {15'd0, c_out, sum}, {15'd0, exp_c, exp_s});
    if (pulse) begin
      for (int i = 0; i < 6; i++) begin
        step();
        if (out_valid !== 1'b0) check("no_second_valid", 32'(out_valid), 32'd0);
      end
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; c_in = 1'b0; sub = 1'b0;
    step(); step();
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_flags", {29'd0, c_out, out_valid, busy}, 32'd0);
    // reset wins over a simultaneous in_valid
    in_valid = 1'b1; a = 16'h1111; b = 16'h1111;
    step();
    in_valid = 1'b0;
    check("rst_no_accept", {30'd0, busy, in_ready}, 32'b01);
    rst = 1'b0;
    step();
    check("idle_ready", 32'(in_ready), 32'd1);

    run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 0, 1'b0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, 1'b0);
    run_op(16'h1234, 16'h4321, 1'b1, 1'b0, 0, 1'b0);
    run_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 3, 1'b0);
    run_op(16'h5A5A, 16'h0F0F, 1'b0, 1'b0, 1, 1'b1);

    // reset in the middle of RUN discards the operation
    a = 16'h1234; b = 16'h1111; c_in = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_result", {15'd0, c_out, sum}, 32'd0);
    check("midrst_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 6; i++) begin
      step();
      if (out_valid !== 1'b0) check("midrst_no_valid", 32'(out_valid), 32'd0);
    end
    run_op(16'd3, 16'd4, 1'b0, 1'b0, 0, 1'b0);

`ifdef CLA_SERIAL_SUB_EN
    run_op(16'h0005, 16'h0007, 1'b1, 1'b1, 0, 1'b0);
    run_op(16'h0007, 16'h0005, 1'b0, 1'b1, 0, 1'b0);
`endif

    for (int n = 0; n < 24; n++) begin
`ifdef CLA_SERIAL_SUB_EN
      run_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(2)), 1'b0);
`else
      run_op(16'($urandom), 16'($urandom), 1'($urandom), 1'b0, int'($urandom_range(2)), 1'b0);
`endif
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
